// File: rtl/mem_responder.sv
// mem_responder: unified CPU instruction/data memory with a big-endian byte-stream loader and a debug probe port.
// Define MEM_CLEAR_ON_RESET_EN to add a zeroing sweep of the whole array after every reset release.
module mem_responder #(
    parameter int DIGIT      = 32,
    parameter int ADDRWIDTH  = 16,
    parameter int DEPTH_LOG2 = 8,
    parameter int DEBUGSIZE  = 8
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  run,
    input  logic [ADDRWIDTH-1:0]  MemAddress,
    input  logic                  MemWrite,
    input  logic [DIGIT-1:0]      WriteData,
    output logic [DIGIT-1:0]      MemData,
    input  logic [7:0]            LoadByte,
    input  logic                  LoadValid,
    input  logic                  LoadStart,
    output logic                  LoadReady,
    output logic [DEPTH_LOG2-1:0] LoadPointer,
    output logic                  LoadWrap,
    output logic                  AlignError,
    output logic                  Busy,
    input  logic [DEBUGSIZE-1:0]  ProbeAddress,
    output logic [DIGIT-1:0]      ProbeMemData
);

    localparam int                    DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] LAST_WORD = DEPTH_LOG2'(DEPTH - 1);

    typedef enum logic {
        S_CLEAR,
        S_ACTIVE
    } state_t;

`ifdef MEM_CLEAR_ON_RESET_EN
    localparam state_t RESET_STATE = S_CLEAR;
`else
    localparam state_t RESET_STATE = S_ACTIVE;
`endif

    logic [DIGIT-1:0]      mem [DEPTH];

    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [DIGIT-9:0]      shift_q, shift_d;
    logic                  wrap_q, wrap_d;
    logic                  align_q, align_d;
`ifdef MEM_CLEAR_ON_RESET_EN
    logic [DEPTH_LOG2-1:0] sweep_q, sweep_d;
`endif

    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_waddr;
    logic [DIGIT-1:0]      mem_wdata;

    logic [DEPTH_LOG2-1:0] cpu_idx;
    logic [DEPTH_LOG2-1:0] probe_idx;
    logic                  clearing;
    logic                  unused_addr_bits;

    // LoadStart restarts the stream on the same edge it is seen, so the loader works from these.
    logic [DEPTH_LOG2-1:0] ld_ptr;
    logic [1:0]            ld_cnt;
    logic                  ld_wrap;

    assign cpu_idx          = MemAddress[DEPTH_LOG2+1:2];
    assign probe_idx        = ProbeAddress[DEPTH_LOG2-1:0];
    assign unused_addr_bits = ^MemAddress[ADDRWIDTH-1:DEPTH_LOG2+2];

    assign ld_ptr  = LoadStart ? '0 : ptr_q;
    assign ld_cnt  = LoadStart ? '0 : cnt_q;
    assign ld_wrap = LoadStart ? 1'b0 : wrap_q;

`ifdef MEM_CLEAR_ON_RESET_EN
    assign clearing = (state_q == S_CLEAR);
`else
    assign clearing = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case can infer a latch.
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        wrap_d    = wrap_q;
        align_d   = align_q;
        mem_we    = 1'b0;
        mem_waddr = cpu_idx;
        mem_wdata = WriteData;
`ifdef MEM_CLEAR_ON_RESET_EN
        sweep_d   = sweep_q;
`endif

        case (state_q)
            S_CLEAR: begin
`ifdef MEM_CLEAR_ON_RESET_EN
                mem_we    = 1'b1;
                mem_waddr = sweep_q;
                mem_wdata = '0;
                sweep_d   = sweep_q + DEPTH_LOG2'(1);
                if (sweep_q == LAST_WORD) begin
                    state_d = S_ACTIVE;
                end
`else
                state_d = S_ACTIVE;
`endif
            end

            S_ACTIVE: begin
                if (run) begin
                    // The CPU owning the port discards any partially assembled loader word.
                    cnt_d = '0;
                    if (MemWrite) begin
                        mem_we = 1'b1;
                    end
                    if (MemAddress[1:0] != 2'b00) begin
                        align_d = 1'b1;
                    end
                end else begin
                    ptr_d  = ld_ptr;
                    cnt_d  = ld_cnt;
                    wrap_d = ld_wrap;
                    if (LoadValid) begin
                        shift_d = {shift_q[DIGIT-17:0], LoadByte};
                        cnt_d   = ld_cnt + 2'd1;
                        if (ld_cnt == 2'd3) begin
                            mem_we    = 1'b1;
                            mem_waddr = ld_ptr;
                            mem_wdata = {shift_q, LoadByte};
                            ptr_d     = ld_ptr + DEPTH_LOG2'(1);
                            if (ld_ptr == LAST_WORD) begin
                                wrap_d = 1'b1;
                            end
                        end
                    end
                end
            end

            default: state_d = S_ACTIVE;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= RESET_STATE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            wrap_q  <= 1'b0;
            align_q <= 1'b0;
`ifdef MEM_CLEAR_ON_RESET_EN
            sweep_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            wrap_q  <= wrap_d;
            align_q <= align_d;
`ifdef MEM_CLEAR_ON_RESET_EN
            sweep_q <= sweep_d;
`endif
        end
    end

    // NOTE: the array has no reset branch so it maps onto RAM; zeroing is the sweep's job.
    always_ff @(posedge CLK) begin
        if (reset && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign MemData      = clearing ? '0 : mem[cpu_idx];
    assign ProbeMemData = clearing ? '0 : mem[probe_idx];
    assign Busy         = clearing;
    assign LoadReady    = !clearing && !run;
    assign LoadPointer  = ptr_q;
    assign LoadWrap     = wrap_q;
    assign AlignError   = align_q;

endmodule
